dmem_sync_port: RTL

DMEM_SYNC_PORT -- requirements
Module: dmem_sync_port

---
 rtl/dmem_sync_port.sv | 89 ++++++++
 1 files changed

// File: rtl/dmem_sync_port.sv
// Single-port word-addressed data memory with byte-enable writes, a one-entry
// response buffer, out-of-range error responses and a saturating error counter.
module dmem_sync_port #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [15:0]         err_count
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [15:0]       r_err_count;

  logic              w_accept;
  logic              w_in_range;
  logic              w_wr;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;

  // A new request fits whenever the response slot is empty or being drained.
  assign req_ready  = !r_rsp_valid || rsp_ready;
  // rst_n gates acceptance so the memory (which has no reset) ignores requests in reset.
  assign w_accept   = rst_n && req_valid && req_ready;
  // Full-width unsigned compare so upper address bits never alias onto valid words.
  assign w_in_range = req_addr < ADDR_W'(DEPTH);
  assign w_idx      = req_addr[IDX_W-1:0];
  assign w_wr       = w_accept && w_in_range && req_we;
  assign w_rd_word  = r_mem[w_idx];

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign err_count  = r_err_count;

  // Storage array: byte-masked writes, deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (req_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Response slot: load on acceptance, hold while stalled, clear once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= !w_in_range;
      r_rsp_rdata <= (w_in_range && !req_we) ? w_rd_word : '0;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Saturating count of accepted out-of-range requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= '0;
    end else if (w_accept && !w_in_range && (r_err_count != CNT_MAX)) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

endmodule
